dfx_mcu_axil_mailbox: RTL and testbench
=======================================

Name: dfx_mcu_axil_mailbox

Overview:
- AXI4-Lite slave register bank and mailbox that consumes the debug-MCU AXI-Lite master port, directly downstream of the MicroBlaze DFX core.
- Provides ID, control, status and scratch registers, plus a write-only mailbox FIFO. The FIFO drains to fabric logic over a valid/ready stream.
- Raises a level interrupt on mailbox overflow or not-empty conditions.

Parameters:
- ADDR_WIDTH, 32, AXI address width; only addr[4:2] is decoded, and any higher set bit produces SLVERR.
- ID_VALUE, 32'hDF40_0001, value returned by the ID register.
- FIFO_DEPTH, 16, mailbox depth in words; must be a power of two, minimum 2.
- CTRL_RESET, 32'h0, reset value of the CTRL register.

Ports:
- AxiBusClock  in  1  sole clock.
- xAxiBusReset_n  in  1  synchronous active-low reset.
- s_axi_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address; awprot is ignored.
- s_axi_awready  out  1
- s_axi_wdata/wstrb/wvalid  in  32/4/1  write data.
- s_axi_wready  out  1
- s_axi_bresp/bvalid  out  2/1;  s_axi_bready  in  1
- s_axi_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1;  s_axi_arready  out  1
- s_axi_rdata/rresp/rvalid  out  32/2/1;  s_axi_rready  in  1
- oCtrl  out  32  CTRL register contents.
- iStatus  in  32  sampled into STATUS on each read.
- oMboxData  out  32  FIFO head;  oMboxValid  out  1;  iMboxReady  in  1
- oIrq  out  1  logical OR of enabled IRQ_STAT bits.

Behaviour:
- Reset values: all ready, valid and resp outputs 0; oCtrl = CTRL_RESET; SCRATCH = 0; FIFO empty; IRQ_STAT = 0; IRQ_EN = 0; oIrq = 0.
- Reset mid-transaction aborts the transaction silently; no response is issued.
- Register map (byte offsets):
  - 0x00 ID: RO.
  - 0x04 CTRL: RW, per-byte wstrb.
  - 0x08 STATUS: RO, returns iStatus.
  - 0x0C SCRATCH: RW, per-byte wstrb.
  - 0x10 MBOX_DATA: WO push; reads return 0.
  - 0x14 MBOX_STAT: RO, {count[15:8], full[1], empty[0]}.
  - 0x18 IRQ_STAT: W1C; bit0 = overflow (sticky), bit1 = not-empty (live, W1C has no effect).
  - 0x1C IRQ_EN: RW, bits[1:0].
- Writes to RO registers complete with OKAY and are ignored.
- Write channel:
  - AW and W are accepted independently into one-entry holding registers. awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Once both are held, the write commits on that cycle and bvalid rises the next cycle. aw_held and w_held clear on commit.
  - One outstanding write only. bvalid holds until bready; a new accept is possible the cycle after the B handshake.
- Read channel:
  - arready = !rvalid. rvalid rises one cycle after the AR handshake, and rdata/rresp stay stable until rready.
- Decode error (any addr[ADDR_WIDTH-1:5] bit set): SLVERR, no side effects; reads return 0.
- Mailbox push:
  - A commit to MBOX_DATA with wstrb != 4'hF returns SLVERR and no push.
  - Push when full (judged by pre-cycle state, even if a pop occurs the same cycle): data is dropped, overflow is set, and bresp = SLVERR.
- Mailbox pop:
  - oMboxValid = !empty; oMboxData = head, stable while valid && !ready.
  - Pop occurs on oMboxValid && iMboxReady.
  - Simultaneous push and pop when not full leaves count unchanged.
  - count range is 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- W1C behaviour: a W1C clear and a new overflow event in the same cycle leave the bit set.
- oIrq is registered: one cycle after a state change, oIrq = |(IRQ_STAT & IRQ_EN).
- Simultaneous AR and AW/W on the same register: both proceed. The read returns the pre-write value if it is captured on or before the commit cycle.

Decomposition:
- Package dfx_mailbox_pkg holds:
  - register offset localparams (REG_ID..REG_IRQ_EN);
  - the AXI resp constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - a typedef for the MBOX_STAT layout.
- One sub-module, dfx_sync_fifo (parameters WIDTH and DEPTH; ports push/pop/full/empty/count), instantiated for the mailbox.

Test Plan:
- Reset, then read 0x00, 0x04, 0x14 -> 32'hDF40_0001 OKAY; 0x0; 32'h0000_0001 (empty); oIrq = 0.
- Write 0x0C = 32'hA5A5_A5A5, then write 0x0C = 32'h0000_1234 with wstrb 4'b0011 -> readback 32'hA5A5_1234. Drive W two cycles before AW -> single B response, one cycle after AW acceptance.
- With iMboxReady = 0, push 16 words 1..16, then a 17th = 99 -> first 16 OKAY, the 17th SLVERR. MBOX_STAT = 32'h0000_1002; IRQ_STAT bit0 = 1; with IRQ_EN = 1, oIrq = 1.
- Raise iMboxReady -> oMboxData presents 1..16 in order, one per cycle, then oMboxValid = 0. Write 0x18 = 1 -> bit0 clears and oIrq falls the next cycle.
- With count = 3, push and pop in the same cycle -> count stays 3 and the data order is preserved.
- Read 0x40 -> rresp SLVERR, rdata 0. Hold rready = 0 for 5 cycles -> rvalid and rdata stable and arready = 0 throughout. Assert reset while bvalid = 1 -> bvalid = 0 on the next cycle.

Source files
------------

// File: rtl/dfx_mailbox_pkg.sv
// rtl/dfx_mailbox_pkg.sv - register map, response codes and shared helpers for the MCU mailbox
package dfx_mailbox_pkg;

    localparam logic [4:0] REG_ID        = 5'h00;
    localparam logic [4:0] REG_CTRL      = 5'h04;
    localparam logic [4:0] REG_STATUS    = 5'h08;
    localparam logic [4:0] REG_SCRATCH   = 5'h0C;
    localparam logic [4:0] REG_MBOX_DATA = 5'h10;
    localparam logic [4:0] REG_MBOX_STAT = 5'h14;
    localparam logic [4:0] REG_IRQ_STAT  = 5'h18;
    localparam logic [4:0] REG_IRQ_EN    = 5'h1C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [5:0]  rsvd_lo;
        logic        full;
        logic        empty;
    } mbox_stat_t;

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dfx_sync_fifo.sv
// rtl/dfx_sync_fifo.sv - single-clock FIFO with occupancy count; push when full and pop when empty are ignored
module dfx_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,        // sole clock
    input  logic                     resetn,     // synchronous active-low reset
    input  logic                     push,       // write push_data this cycle
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,        // retire head this cycle
    output logic [WIDTH-1:0]         pop_data,   // head entry
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count       // 0..DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers are AW bits wide, so a power-of-two DEPTH wraps for free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/dfx_mcu_axil_mailbox.sv
// rtl/dfx_mcu_axil_mailbox.sv - AXI4-Lite register bank with write-only mailbox FIFO and level interrupt
module dfx_mcu_axil_mailbox
    import dfx_mailbox_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'hDF40_0001,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic                  AxiBusClock,     // sole clock
    input  logic                  xAxiBusReset_n,  // synchronous active-low reset
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,    // write address channel
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,     // write data channel
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,     // write response channel
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,    // read address channel
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,     // read data channel
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           oCtrl,           // CTRL register
    input  logic [31:0]           iStatus,         // live status, captured by STATUS reads
    output logic [31:0]           oMboxData,       // mailbox head
    output logic                  oMboxValid,
    input  logic                  iMboxReady,
    output logic                  oIrq             // registered |(IRQ_STAT & IRQ_EN)
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  up;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic [31:0]           scratch;
    logic                  ovf;
    logic [1:0]            irq_en;

    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    mbox_stat_t            mbox_stat;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [4:0]            wr_off, rd_off;
    logic                  wr_err, rd_err, mbox_sel, push, ovf_evt, ovf_clr;
    logic [1:0]            wr_resp;
    logic [31:0]           rd_val;
    logic                  unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_araddr[1:0], aw_addr[1:0]};

    // up keeps every ready low while reset is applied and on the first cycle after it.
    assign s_axi_awready = up && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = up && !w_held && !s_axi_bvalid;
    assign s_axi_arready = up && !s_axi_rvalid;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_held && w_held;

    assign wr_off   = {aw_addr[4:2], 2'b00};
    assign wr_err   = |aw_addr[ADDR_WIDTH-1:5];
    assign mbox_sel = commit && !wr_err && (wr_off == REG_MBOX_DATA);
    // Fullness is judged on pre-cycle state, so a same-cycle pop cannot rescue a push.
    assign push     = mbox_sel && (w_strb == 4'hF) && !fifo_full;
    assign ovf_evt  = mbox_sel && (w_strb == 4'hF) && fifo_full;
    assign ovf_clr  = commit && !wr_err && (wr_off == REG_IRQ_STAT) && w_strb[0] && w_data[0];
    assign wr_resp  = (wr_err || (mbox_sel && ((w_strb != 4'hF) || fifo_full))) ? RESP_SLVERR : RESP_OKAY;

    assign oMboxValid = !fifo_empty;

    always_comb begin
        mbox_stat         = '0;
        mbox_stat.count   = 8'(fifo_count);
        mbox_stat.full    = fifo_full;
        mbox_stat.empty   = fifo_empty;
    end

    assign rd_off = {s_axi_araddr[4:2], 2'b00};
    assign rd_err = |s_axi_araddr[ADDR_WIDTH-1:5];

    always_comb begin
        rd_val = '0;
        if (!rd_err) begin
            case (rd_off)
                REG_ID:        rd_val = ID_VALUE;
                REG_CTRL:      rd_val = oCtrl;
                REG_STATUS:    rd_val = iStatus;
                REG_SCRATCH:   rd_val = scratch;
                REG_MBOX_STAT: rd_val = mbox_stat;
                REG_IRQ_STAT:  rd_val = {30'd0, !fifo_empty, ovf};
                REG_IRQ_EN:    rd_val = {30'd0, irq_en};
                default:       rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge AxiBusClock) begin
        if (!xAxiBusReset_n) begin
            up           <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr      <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
            oCtrl        <= CTRL_RESET;
            scratch      <= '0;
            ovf          <= 1'b0;
            irq_en       <= '0;
            oIrq         <= 1'b0;
        end else begin
            up <= 1'b1;
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_resp;
                if (!wr_err) begin
                    case (wr_off)
                        REG_CTRL:    oCtrl   <= apply_strb(oCtrl, w_data, w_strb);
                        REG_SCRATCH: scratch <= apply_strb(scratch, w_data, w_strb);
                        REG_IRQ_EN:  if (w_strb[0]) irq_en <= w_data[1:0];
                        default:     ;
                    endcase
                end
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            // A new overflow wins over a same-cycle W1C.
            ovf <= (ovf && !ovf_clr) || ovf_evt;
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
            oIrq <= |({!fifo_empty, ovf} & irq_en);
        end
    end

    dfx_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_mbox_fifo (
        .clk       (AxiBusClock),
        .resetn    (xAxiBusReset_n),
        .push      (push),
        .push_data (w_data),
        .pop       (oMboxValid && iMboxReady),
        .pop_data  (oMboxData),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_dfx_mcu_axil_mailbox.sv
// tb/tb_dfx_mcu_axil_mailbox.sv - directed self-checking bench for the MCU mailbox
module tb_dfx_mcu_axil_mailbox;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] awaddr, wdata, araddr, rdata, ctrl, status, mbox_data;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        mbox_valid, mbox_ready, irq;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dfx_mcu_axil_mailbox dut (
        .AxiBusClock    (clk),
        .xAxiBusReset_n (resetn),
        .s_axi_awaddr   (awaddr),
        .s_axi_awprot   (awprot),
        .s_axi_awvalid  (awvalid),
        .s_axi_awready  (awready),
        .s_axi_wdata    (wdata),
        .s_axi_wstrb    (wstrb),
        .s_axi_wvalid   (wvalid),
        .s_axi_wready   (wready),
        .s_axi_bresp    (bresp),
        .s_axi_bvalid   (bvalid),
        .s_axi_bready   (bready),
        .s_axi_araddr   (araddr),
        .s_axi_arprot   (arprot),
        .s_axi_arvalid  (arvalid),
        .s_axi_arready  (arready),
        .s_axi_rdata    (rdata),
        .s_axi_rresp    (rresp),
        .s_axi_rvalid   (rvalid),
        .s_axi_rready   (rready),
        .oCtrl          (ctrl),
        .iStatus        (status),
        .oMboxData      (mbox_data),
        .oMboxValid     (mbox_valid),
        .iMboxReady     (mbox_ready),
        .oIrq           (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        logic ok, aw_now, w_now, b_now;
        ok = 1'b0;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            b_now  = bvalid;
            if (b_now) resp = bresp;
            tick();
            if (aw_now) awvalid = 1'b0;
            if (w_now)  wvalid = 1'b0;
            if (b_now)  ok = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        chk("wr_done", {31'd0, ok}, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ok, ar_now;
        ok = 1'b0;
        d = 'x; r = 'x;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            ar_now = arvalid && arready;
            if (rvalid) begin
                d = rdata; r = rresp; ok = 1'b1;
            end
            tick();
            if (ar_now) arvalid = 1'b0;
        end
        arvalid = 1'b0; rready = 1'b0;
        chk("rd_done", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int bad;

        resetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        status = 32'h1357_9BDF; mbox_ready = 1'b0;
        repeat (3) tick();

        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_ctrl", ctrl, 32'h0);
        chk("rst_mbox_valid", {31'd0, mbox_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        repeat (2) tick();

        axi_read(32'h00, d, r);
        chk("id_data", d, 32'hDF40_0001);
        chk("id_resp", {30'd0, r}, 32'd0);
        axi_read(32'h04, d, r);
        chk("ctrl_rst_data", d, 32'h0);
        axi_read(32'h14, d, r);
        chk("mstat_rst", d, 32'h0000_0001);
        axi_read(32'h08, d, r);
        chk("status_data", d, 32'h1357_9BDF);
        chk("irq_idle", {31'd0, irq}, 32'd0);

        axi_write(32'h0C, 32'hA5A5_A5A5, 4'hF, r);
        chk("scr_wr_resp", {30'd0, r}, 32'd0);
        axi_write(32'h0C, 32'h0000_1234, 4'b0011, r);
        axi_read(32'h0C, d, r);
        chk("scr_strb_data", d, 32'hA5A5_1234);

        axi_write(32'h00, 32'h0, 4'hF, r);
        chk("ro_wr_resp", {30'd0, r}, 32'd0);
        axi_read(32'h00, d, r);
        chk("ro_wr_ignored", d, 32'hDF40_0001);

        // W leads AW by two cycles; the B response must follow AW by one cycle.
        wdata = 32'h0000_00FF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        chk("w_only_no_b", {31'd0, bvalid}, 32'd0);
        awaddr = 32'h04; awvalid = 1'b1;
        chk("aw_ready_after_w", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        chk("b_not_yet", {31'd0, bvalid}, 32'd0);
        tick();
        chk("b_after_aw", {31'd0, bvalid}, 32'd1);
        chk("b_after_aw_resp", {30'd0, bresp}, 32'd0);
        tick();
        chk("b_single", {31'd0, bvalid}, 32'd0);
        bready = 1'b0;
        tick();
        chk("b_single_2", {31'd0, bvalid}, 32'd0);
        chk("ctrl_out", ctrl, 32'h0000_00FF);

        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            axi_write(32'h10, i, 4'hF, r);
            if (r !== 2'b00) bad++;
        end
        chk("push16_okay", bad, 32'd0);
        axi_write(32'h10, 32'd99, 4'hF, r);
        chk("push_full_slverr", {30'd0, r}, 32'd2);
        axi_read(32'h14, d, r);
        chk("mstat_full", d, 32'h0000_1002);
        axi_read(32'h18, d, r);
        chk("irq_stat_ovf", d, 32'h0000_0003);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        axi_write(32'h1C, 32'h1, 4'hF, r);
        repeat (2) tick();
        chk("irq_on", {31'd0, irq}, 32'd1);

        mbox_ready = 1'b1;
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (!mbox_valid || mbox_data !== i) bad++;
            tick();
        end
        chk("drain_order", bad, 32'd0);
        chk("drain_empty", {31'd0, mbox_valid}, 32'd0);
        axi_write(32'h18, 32'h1, 4'hF, r);
        chk("w1c_resp", {30'd0, r}, 32'd0);
        chk("irq_off", {31'd0, irq}, 32'd0);
        axi_read(32'h18, d, r);
        chk("irq_stat_clr", d, 32'h0);

        mbox_ready = 1'b0;
        axi_write(32'h10, 32'h11, 4'hF, r);
        axi_write(32'h10, 32'h22, 4'hF, r);
        axi_write(32'h10, 32'h33, 4'hF, r);
        axi_read(32'h14, d, r);
        chk("mstat_cnt3", d, 32'h0000_0300);
        // AW+W accepted on one edge, commit (push) on the next, with a pop aligned to it.
        awaddr = 32'h10; wdata = 32'h44; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("head_before_pop", mbox_data, 32'h11);
        mbox_ready = 1'b1;
        tick();
        mbox_ready = 1'b0;
        chk("pp_bvalid", {31'd0, bvalid}, 32'd1);
        chk("pp_bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        axi_read(32'h14, d, r);
        chk("pp_cnt3", d, 32'h0000_0300);
        axi_write(32'h10, 32'h55, 4'h7, r);
        chk("push_strb_slverr", {30'd0, r}, 32'd2);
        axi_read(32'h14, d, r);
        chk("strb_no_push", d, 32'h0000_0300);
        mbox_ready = 1'b1;
        bad = 0;
        if (!mbox_valid || mbox_data !== 32'h22) bad++;
        tick();
        if (!mbox_valid || mbox_data !== 32'h33) bad++;
        tick();
        if (!mbox_valid || mbox_data !== 32'h44) bad++;
        tick();
        mbox_ready = 1'b0;
        chk("pp_order", bad, 32'd0);
        chk("pp_empty", {31'd0, mbox_valid}, 32'd0);

        axi_write(32'h2C, 32'h0, 4'hF, r);
        chk("dec_wr_slverr", {30'd0, r}, 32'd2);
        axi_read(32'h0C, d, r);
        chk("dec_wr_no_effect", d, 32'hA5A5_1234);

        araddr = 32'h40; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10 || arready !== 1'b0) bad++;
            tick();
        end
        chk("rd_err_hold", bad, 32'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rd_err_done", {31'd0, rvalid}, 32'd0);

        awaddr = 32'h0C; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
        resetn = 1'b0;
        tick();
        chk("rst_abort_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_ctrl_again", ctrl, 32'h0);
        resetn = 1'b1;
        repeat (2) tick();
        chk("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
        axi_read(32'h0C, d, r);
        chk("post_rst_scratch", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
